// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the BCD<->binary conversion paths.
// Holds the converter state encoding, digit constants and a digit-range
// helper. The binary-to-BCD display path uses the same digit width and
// max-digit constants with its own 5/+3 adjust rule.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned BCD_MAX_DIGIT  = 9;
  localparam int unsigned BCD_ADJ_THRESH = 8;
  localparam int unsigned BCD_ADJ_VAL    = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_e;

  // True when a 4-bit field is not a legal decimal digit.
  function automatic logic bcd_digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble digit correction (combinational).
// After a right shift, a digit that is >= 8 has received a bit worth 8
// from the digit above it, which in decimal is worth only 5, so 3 is
// removed.
//   i_digit : shifted BCD digit
//   o_digit : corrected BCD digit
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
      o_digit = i_digit - BCD_DIGIT_W'(BCD_ADJ_VAL);
    end
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter, one result bit per clock.
// A packed BCD operand is accepted on in_valid & in_ready, converted by
// reverse double-dabble over 4*DIGITS shift cycles, and presented on
// bin_out/err under out_valid until out_ready. Operands containing a
// digit > 9 skip conversion and return err = 1, bin_out = 0.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : bcd_in valid
//   in_ready  : converter idle and able to accept
//   bcd_in    : packed BCD operand, digit 0 in bits [3:0]
//   out_valid : bin_out/err valid
//   out_ready : consumer accepts the result
//   bin_out   : binary result, zero-extended to BIN_W
//   err       : operand held a digit > 9
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          err
);

  localparam int unsigned NB = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CW = $clog2(NB + 1);

  if (BIN_W < NB) begin : g_width_check
    $error("bcd_to_binary_seq: BIN_W must be at least 4*DIGITS");
  end

  bcd_state_e r_state;
  bcd_state_e w_state_next;

  logic [NB-1:0]    r_digits;
  logic [NB-1:0]    r_bin;
  logic [CW-1:0]    r_cnt;
  logic [BIN_W-1:0] r_bin_out;
  logic             r_err;

  logic [NB-1:0]    w_shift_digits;
  logic [NB-1:0]    w_adj_digits;
  logic [NB-1:0]    w_shift_bin;
  logic [CW-1:0]    w_cnt_dec;
  logic             w_last;
  logic             w_bad_digit;
  logic             w_accept;

  always_comb begin
    w_bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_digit_invalid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
        w_bad_digit = 1'b1;
      end
    end
  end

  // {digits, binary} shifted right as one word: digit LSB feeds binary MSB.
  always_comb begin
    w_shift_digits = {1'b0, r_digits[NB-1:1]};
    w_shift_bin    = {r_digits[0], r_bin[NB-1:1]};
    w_cnt_dec      = r_cnt - CW'(1);
    w_last         = (w_cnt_dec == '0);
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (w_shift_digits[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj_digits[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = w_bad_digit ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits  <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_bin_out <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_digits <= bcd_in;
            r_bin    <= '0;
            r_cnt    <= CW'(NB);
            if (w_bad_digit) begin
              r_bin_out <= '0;
              r_err     <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_digits <= w_adj_digits;
          r_bin    <= w_shift_bin;
          r_cnt    <= w_cnt_dec;
          // Final iteration: the result is the shifted binary word itself.
          if (w_last) begin
            r_bin_out <= BIN_W'(w_shift_bin);
            r_err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bin_out = r_bin_out;
  assign err     = r_err;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
module tb_bcd_to_binary_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  bcd_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] bin_out;
  logic        err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  bcd_to_binary_seq #(
    .DIGITS (2),
    .BIN_W  (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: no response within cycle budget (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] bin;
    logic        err;
    int unsigned lat;   // edges after accept before the result is visible
  } exp_t;

  exp_t        q[$];
  int unsigned n_since = 0;
  logic [31:0] m_bin   = '0;
  logic        m_err   = 1'b0;

  function automatic exp_t model_of(input logic [7:0] b);
    exp_t        e;
    int unsigned val   = 0;
    int unsigned scale = 1;
    int unsigned d;
    e.err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = int'((b >> (4 * i)) & 8'hF);
      if (d > 9) e.err = 1'b1;
      val += d * scale;
      scale *= 10;
    end
    e.bin = e.err ? 32'd0 : val;
    e.lat = e.err ? 0 : 8;
    return e;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        n_since = 0;
        m_bin   = '0;
        m_err   = 1'b0;
      end else if (q.size() > 0) begin
        if (n_since >= q[0].lat && out_ready) begin
          void'(q.pop_front());
        end else begin
          n_since++;
          if (n_since == q[0].lat) begin
            m_bin = q[0].bin;
            m_err = q[0].err;
          end
        end
      end else if (in_valid) begin
        e = model_of(bcd_in);
        q.push_back(e);
        n_since = 0;
        if (e.lat == 0) begin
          m_bin = e.bin;
          m_err = e.err;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    logic exp_ov;
    @(negedge clk);
    exp_ov = 1'b0;
    if (q.size() > 0) exp_ov = (n_since >= q[0].lat);
    chk("m_in_ready", 32'(in_ready), 32'(q.size() == 0));
    chk("m_out_valid", 32'(out_valid), 32'(exp_ov));
    chk("m_bin_out", bin_out, m_bin);
    chk("m_err", 32'(err), 32'(m_err));
  end

  // ---------------- directed stimulus ----------------
  // Presents b until accepted; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] b);
    int k = 0;
    @(negedge clk);
    in_valid = 1'b1;
    bcd_in   = b;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) timeout_fail("send");
    @(negedge clk);
    in_valid = 1'b0;
    bcd_in   = ~b;
  endtask

  task automatic check_op(input logic [7:0] b, input logic [31:0] want_bin,
                          input logic want_err, input int want_lat);
    int k = 0;
    send(b);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(want_lat));
    chk("bin_out", bin_out, want_bin);
    chk("err", 32'(err), 32'(want_err));
  endtask

  initial begin
    int          k;
    int unsigned acc;
    int unsigned prev_acc;
    logic [7:0]  b;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    bcd_in    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bin_out", bin_out, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    check_op(8'h99, 32'd99, 1'b0, 8);
    check_op(8'h00, 32'd0, 1'b0, 8);
    check_op(8'h10, 32'd10, 1'b0, 8);
    check_op(8'h5A, 32'd0, 1'b1, 0);
    check_op(8'h42, 32'd42, 1'b0, 8);

    // Backpressure.
    @(negedge clk);
    out_ready = 1'b0;
    send(8'h37);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_latency", 32'(k), 32'd8);
    for (int i = 0; i < 5; i++) begin
      chk("bp_bin_out", bin_out, 32'd37);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_hold_bin_out", bin_out, 32'd37);

    // Reset in the middle of a conversion.
    send(8'h77);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_bin_out", bin_out, 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    end
    check_op(8'h77, 32'd77, 1'b0, 8);

    // Back-to-back sweep 00..99; results checked by the model each cycle.
    @(negedge clk);
    out_ready = 1'b1;
    prev_acc  = 0;
    for (int i = 0; i < 100; i++) begin
      b = {4'(i / 10), 4'(i % 10)};
      @(negedge clk);
      bcd_in   = b;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 30) begin
        @(negedge clk);
        k++;
      end
      if (k >= 30) timeout_fail("sweep_accept");
      acc = cyc + 1;
      if (i > 0) chk("sweep_interval", acc - prev_acc, 32'd10);
      prev_acc = acc;
    end
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("sweep_last_bin_out", bin_out, 32'd99);
    repeat (3) @(negedge clk);
    chk("end_in_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
